// File: rtl/scan_display_4d_pkg.sv
// Shared constants for the multiplexed 7-segment display blocks.
// The segment table is active-low, with segments a..g in bits [0]..[6].
package scan_display_4d_pkg;

    localparam int NDIG = 4;
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/scan_display_4d_hex7seg.sv
// Combinational decoder from a nibble to active-low 7-segment patterns.
// Other display blocks can reuse it.
module hex7seg_n
    import scan_display_4d_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/scan_display_4d.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame input capture,
// decimal points, blanking and leading-zero suppression.
module scan_display_4d
    import scan_display_4d_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    input  logic        lz_en,
    output logic [6:0]  segment,
    output logic        dp,
    output logic [3:0]  AN,
    output logic        frame_tick
);

    logic [DIV_W-1:0] prescaler;
    logic             tick;
    logic             capture;
    digit_idx_t       idx;

    logic [15:0]      sh_data;
    logic [3:0]       sh_dp;
    logic [3:0]       sh_blank;
    logic             sh_lz;

    logic [3:0]       nib;
    logic [6:0]       seg_val;
    logic [NDIG-1:0]  upper_zero;
    logic             dark;

    assign tick    = (prescaler == DIV_W'(SCAN_DIV - 1));
    assign capture = tick && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
        end
    end

    // Inputs are sampled only at the end of digit 3 so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_lz      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= capture;
            if (capture) begin
                sh_data  <= data;
                sh_dp    <= dp_in;
                sh_blank <= blank;
                sh_lz    <= lz_en;
            end
        end
    end

    assign nib = sh_data[{idx, 2'b00} +: 4];

    hex7seg_n u_hex7seg (
        .nib (nib),
        .seg (seg_val)
    );

    // upper_zero[i]: nibble i and every more significant nibble are zero.
    always_comb begin
        upper_zero    = '0;
        upper_zero[3] = (sh_data[15:12] == 4'h0);
        upper_zero[2] = (sh_data[11:8]  == 4'h0) && upper_zero[3];
        upper_zero[1] = (sh_data[7:4]   == 4'h0) && upper_zero[2];
        upper_zero[0] = (sh_data[3:0]   == 4'h0) && upper_zero[1];
        dark = sh_blank[idx] || (sh_lz && (idx != 2'd0) && upper_zero[idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AN      <= AN_OFF;
            segment <= SEG_BLANK;
            dp      <= 1'b1;
        end else begin
            AN      <= ~(4'b0001 << idx);
            segment <= dark ? SEG_BLANK : seg_val;
            dp      <= dark ? 1'b1 : ~sh_dp[idx];
        end
    end

endmodule

// File: tb/tb_scan_display_4d.sv
// Directed bench for scan_display_4d with a short scan period (4 cycles per digit).
module tb_scan_display_4d;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz_en;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  AN;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    scan_display_4d #(.SCAN_DIV(4), .DIV_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .dp_in      (dp_in),
        .blank      (blank),
        .lz_en      (lz_en),
        .segment    (segment),
        .dp         (dp),
        .AN         (AN),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for 3 cycles, then release away from the clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        data = 16'h1234; dp_in = 4'h0; blank = 4'h0; lz_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (AN !== 4'hF || segment !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_values: AN=%h seg=%h dp=%b ft=%b, want AN=f seg=7f dp=1 ft=0",
                     AN, segment, dp, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            exp_an = ~(4'b0001 << ((e - 1) / 4));
            total++;
            if (AN !== exp_an || segment !== 7'h40 || dp !== 1'b1 || frame_tick !== (e == 16)) begin
                bad++;
                $display("[TB] FAIL first_frame e=%0d: AN=%b seg=%h dp=%b ft=%b, want AN=%b seg=40 dp=1 ft=%b",
                         e, AN, segment, dp, frame_tick, exp_an, (e == 16));
            end
        end
    endtask

    task automatic test_capture();
        logic [6:0] exp_seg [3][4];
        logic [3:0] exp_an;
        logic [6:0] es;
        int f, d;
        exp_seg[0] = '{7'h40, 7'h40, 7'h40, 7'h40};
        exp_seg[1] = '{7'h79, 7'h40, 7'h00, 7'h08};
        exp_seg[2] = '{7'h0E, 7'h0E, 7'h0E, 7'h0E};
        data = 16'hA801; dp_in = 4'h0; blank = 4'h0; lz_en = 1'b0;
        do_reset();
        for (int e = 1; e <= 48; e++) begin
            @(posedge clk); #1;
            f = (e - 1) / 16;
            d = ((e - 1) % 16) / 4;
            exp_an = ~(4'b0001 << d);
            es = exp_seg[f][d];
            total++;
            if (AN !== exp_an || segment !== es || dp !== 1'b1 || frame_tick !== (e % 16 == 0)) begin
                bad++;
                $display("[TB] FAIL capture e=%0d: AN=%b seg=%h dp=%b ft=%b, want AN=%b seg=%h dp=1 ft=%b",
                         e, AN, segment, dp, frame_tick, exp_an, es, (e % 16 == 0));
            end
            if (e == 24)
                data = 16'hFFFF;
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_seg [3][4];
        logic [3:0] exp_an;
        logic [6:0] es;
        int f, d;
        exp_seg[0] = '{7'h40, 7'h40, 7'h40, 7'h40};
        exp_seg[1] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        exp_seg[2] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        data = 16'h0050; dp_in = 4'h0; blank = 4'h0; lz_en = 1'b1;
        do_reset();
        for (int e = 1; e <= 48; e++) begin
            @(posedge clk); #1;
            f = (e - 1) / 16;
            d = ((e - 1) % 16) / 4;
            exp_an = ~(4'b0001 << d);
            es = exp_seg[f][d];
            total++;
            if (AN !== exp_an || segment !== es || dp !== 1'b1) begin
                bad++;
                $display("[TB] FAIL leading_zero e=%0d: AN=%b seg=%h dp=%b, want AN=%b seg=%h dp=1",
                         e, AN, segment, dp, exp_an, es);
            end
            if (e == 20)
                data = 16'h0000;
        end
    endtask

    // Runs into the digit-2 slot of the second frame and leaves the DUT there.
    task automatic test_points_blank();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_dp;
        logic [3:0] exp_an;
        logic [6:0] es;
        logic       ed;
        int d;
        exp_seg = '{7'h40, 7'h79, 7'h7F, 7'h30};
        exp_dp  = 4'b1110;
        data = 16'h3210; dp_in = 4'b0101; blank = 4'b0100; lz_en = 1'b0;
        do_reset();
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk); #1;
            d = ((e - 1) % 16) / 4;
            exp_an = ~(4'b0001 << d);
            es = (e <= 16) ? 7'h40 : exp_seg[d];
            ed = (e <= 16) ? 1'b1 : exp_dp[d];
            total++;
            if (AN !== exp_an || segment !== es || dp !== ed) begin
                bad++;
                $display("[TB] FAIL points_blank e=%0d: AN=%b seg=%h dp=%b, want AN=%b seg=%h dp=%b",
                         e, AN, segment, dp, exp_an, es, ed);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_an;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (AN !== 4'hF || segment !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: AN=%h seg=%h dp=%b ft=%b, want AN=f seg=7f dp=1 ft=0",
                     AN, segment, dp, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            exp_an = (e <= 4) ? 4'b1110 : 4'b1101;
            total++;
            if (AN !== exp_an || segment !== 7'h40 || dp !== 1'b1) begin
                bad++;
                $display("[TB] FAIL after_async e=%0d: AN=%b seg=%h dp=%b, want AN=%b seg=40 dp=1",
                         e, AN, segment, dp, exp_an);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        data  = '0;
        dp_in = '0;
        blank = '0;
        lz_en = 1'b0;
        test_reset();
        test_capture();
        test_leading_zero();
        test_points_blank();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_display_4d.md
Name: scan_display_4d

Overview:
- Time-multiplexed 4-digit 7-segment driver, downstream of the counter/decoder path.
- Takes four hex nibbles, per-digit decimal points and blanking masks, and scans them onto the shared, active-low `segment`/`AN` lines of the board display.
- Replaces the static single-digit hookup: all four digits are lit by cycling the anode enables at a refresh rate set by a prescaler.
- Input data is captured once per frame so a changing counter value never tears mid-scan.

Parameters:
- `SCAN_DIV`, 100000, clk cycles each digit stays lit (≥2). 100000 gives 1 kHz digit rate, 250 Hz frame rate at 100 MHz.
- `DIV_W`, 17, prescaler width. Must satisfy 2^DIV_W ≥ `SCAN_DIV`.

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `data`  in  16  digit values; [3:0]=digit0 (rightmost) … [15:12]=digit3
- `dp_in`  in  4  decimal point request per digit, active-high
- `blank`  in  4  force digit dark, active-high
- `lz_en`  in  1  leading-zero suppression enable
- `segment`  out  7  segments a..g = [0]..[6], active-low, registered
- `dp`  out  1  decimal point, active-low, registered
- `AN`  out  4  digit anode enables, active-low, one-hot-low, registered
- `frame_tick`  out  1  one-cycle pulse when a new frame's data is captured

Behaviour:
- Reset is asynchronous on `rst_n`=0. Every register is cleared immediately:
  - prescaler=0, idx=0, shadow registers (data/dp/blank/lz)=0
  - `AN`=4'b1111 (all off), `segment`=7'h7F, `dp`=1, `frame_tick`=0
- Prescaler:
  - Counts 0..`SCAN_DIV`-1 and wraps.
  - `tick`=1 in the cycle where prescaler==`SCAN_DIV`-1.
- Digit index `idx` (2 bits):
  - Increments on `tick`: 0→1→2→3→0.
  - Each digit dwells exactly `SCAN_DIV` cycles.
- Frame capture:
  - On `tick` with idx==3, shadow ← {`data`, `dp_in`, `blank`, `lz_en`}, sampled in that cycle.
  - `frame_tick`=1 in the following cycle only.
  - Frame period is 4×`SCAN_DIV` cycles.
  - Input changes at any other time have no effect until the next capture.
  - The first frame after reset displays shadow=0, i.e. "0000" with no points.
- Output stage:
  - The output registers load every cycle from the current idx and shadow, so outputs lag an idx change by 1 cycle.
  - `AN`[idx]=0, all other bits 1. Exactly one bit is low at any time after the first post-reset cycle.
  - Digit value nib = shadow_data[4*idx+3 : 4*idx].
  - `segment` = hex7seg(nib), active-low: 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E, full 0–F table.
  - `dp` = ~shadow_dp[idx].
- Suppression (dark digit: `segment`=7'h7F and `dp`=1, while `AN` still cycles normally to keep duty uniform):
  - shadow_blank[idx]=1.
  - Or shadow_lz=1, idx≥1, and nibble idx plus every higher nibble are zero.
  - Digit 0 is never leading-zero suppressed, so a value of 0 shows "   0".
  - `blank` overrides `dp`.
- Reset asserted mid-frame: all outputs return immediately to their reset values. After release, scanning restarts at digit 0 with a full `SCAN_DIV` dwell.

Decomposition:
- Shared package holds:
  - `NDIG`=4
  - `AN_OFF`=4'b1111
  - `SEG_BLANK`=7'h7F
  - the 16-entry active-low hex segment constant table
- One sub-module, `hex7seg_n`: combinational 4-bit nibble → 7-bit active-low segments via the package table. It is reusable by other display blocks.
- Prescaler, index, shadow, suppression and output registers stay in `scan_display_4d`.

Test Plan (`SCAN_DIV`=4, `DIV_W`=2):
- Reset: hold `rst_n`=0 for 3 cycles with `data`=16'h1234 → `AN`=4'hF, `segment`=7'h7F, `dp`=1. After release, the first frame shows digit0 `segment`=7'h40 with `AN`=4'b1110 for 4 cycles, then `AN`=4'b1101, 4'b1011, 4'b0111 in turn.
- Capture/no-tear: `data`=16'hA801 applied from reset → second frame shows digit0=7'h79, digit1=7'h40, digit2=7'h00, digit3=7'h08. Change `data` to 16'hFFFF mid-frame → still 16'hA801 until `frame_tick`, then all digits 7'h0E. `frame_tick` period is 16 cycles.
- Leading zeros: `data`=16'h0050, `lz_en`=1 → digit3 dark, digit2 dark, digit1 7'h12 ("5"), digit0 7'h40. With `data`=16'h0000 → only digit0 lit, showing 7'h40.
- Points/blank: `dp_in`=4'b0101, `blank`=4'b0100 → `dp`=0 on digit0 only. Digit2 fully dark (7'h7F, `dp`=1) while `AN`[2] is still driven low in its slot.
- Async reset mid-scan: assert `rst_n`=0 between clock edges while digit2 is lit → `AN`=4'hF before the next edge. After release, digit0 dwells a full 4 cycles.
